// File: rtl/taitosj_pkg.sv
// Shared types and constants for the taitosj hiscore/work-RAM glue.
package taitosj_pkg;
  typedef enum logic [2:0] {IDLE_CPU, REQ, DRAIN, GRANT, RELEASE} arb_state_t;
  localparam logic [7:0] HS_DATA_OOB = 8'hFF;
  localparam int DRAIN_CW = 4;
endpackage

// File: rtl/hs_window_decode.sv
// Splits a CPU-space address into work-RAM window hit and local RAM address.
module hs_window_decode #(
  parameter int HS_AW = 16,
  parameter int RAM_AW = 11,
  parameter logic [HS_AW-1:0] RAM_BASE = 16'h8000
) (
  input  logic [HS_AW-1:0]  addr,
  output logic              in_win,
  output logic [RAM_AW-1:0] local_addr
);
  assign in_win     = (addr[HS_AW-1:RAM_AW] == RAM_BASE[HS_AW-1:RAM_AW]);
  assign local_addr = addr[RAM_AW-1:0];
endmodule

// File: rtl/hiscore_ram_arbiter.sv
// Hands the single work-RAM port to the hiscore engine once the CPU is paused
// and drained, and returns it to the CPU when hiscore intent drops.
module hiscore_ram_arbiter
  import taitosj_pkg::*;
#(
  parameter int HS_AW = 16,
  parameter int RAM_AW = 11,
  parameter logic [HS_AW-1:0] RAM_BASE = 16'h8000,
  parameter int DRAIN_CYC = 4
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic [HS_AW-1:0]  cpu_addr,
  input  logic              cpu_ram_cs,
  input  logic              cpu_we,
  input  logic [7:0]        cpu_dout,
  output logic [7:0]        cpu_din,
  input  logic [HS_AW-1:0]  hs_address,
  input  logic [7:0]        hs_data_in,
  input  logic              hs_write,
  input  logic              hs_access_read,
  input  logic              hs_access_write,
  output logic [7:0]        hs_data_out,
  output logic              hs_pause,
  input  logic              pause_cpu,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  output logic              hs_granted,
  output logic              hs_oob,
  output logic              hs_abort
);
  arb_state_t          state;
  logic [DRAIN_CW-1:0] drain_cnt;
  logic                intent;
  logic                hs_win, cpu_win_unused;
  logic [RAM_AW-1:0]   hs_local, cpu_local;
  logic                rd_pend, rd_oob;
  logic [7:0]          cpu_hold;

  assign intent = hs_access_read | hs_access_write;

  hs_window_decode #(.HS_AW(HS_AW), .RAM_AW(RAM_AW), .RAM_BASE(RAM_BASE)) u_hs_dec (
    .addr(hs_address), .in_win(hs_win), .local_addr(hs_local)
  );
  // CPU side trusts cpu_ram_cs for selection; only the local address is used.
  hs_window_decode #(.HS_AW(HS_AW), .RAM_AW(RAM_AW), .RAM_BASE(RAM_BASE)) u_cpu_dec (
    .addr(cpu_addr), .in_win(cpu_win_unused), .local_addr(cpu_local)
  );

  always_comb begin
    ram_addr  = cpu_local;
    ram_we    = cpu_ram_cs & cpu_we;
    ram_wdata = cpu_dout;
    cpu_din   = ram_rdata;
    if (state == GRANT) begin
      ram_addr  = hs_local;
      ram_we    = hs_write & hs_win;
      ram_wdata = hs_data_in;
      cpu_din   = cpu_hold;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= IDLE_CPU;
      hs_pause   <= 1'b0;
      hs_granted <= 1'b0;
      hs_abort   <= 1'b0;
      drain_cnt  <= '0;
    end else begin
      case (state)
        IDLE_CPU: if (intent) begin
          state    <= REQ;
          hs_pause <= 1'b1;
        end
        REQ: if (!intent) begin
          state    <= RELEASE;
          hs_pause <= 1'b0;
        end else if (pause_cpu) begin
          state     <= DRAIN;
          drain_cnt <= DRAIN_CW'(DRAIN_CYC - 1);
        end
        DRAIN: if (!intent) begin
          state    <= RELEASE;
          hs_pause <= 1'b0;
        end else if (!pause_cpu) begin
          state <= REQ;
        end else if (drain_cnt == '0) begin
          state      <= GRANT;
          hs_granted <= 1'b1;
        end else begin
          drain_cnt <= drain_cnt - 1'b1;
        end
        GRANT: if (!intent || !pause_cpu) begin
          state      <= RELEASE;
          hs_pause   <= 1'b0;
          hs_granted <= 1'b0;
          if (!pause_cpu) hs_abort <= 1'b1;
        end
        RELEASE: state <= IDLE_CPU;
        default: begin
          state      <= IDLE_CPU;
          hs_pause   <= 1'b0;
          hs_granted <= 1'b0;
        end
      endcase
    end
  end

  // Hiscore read data lands one cycle after the synchronous RAM returns it.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      hs_oob      <= 1'b0;
      hs_data_out <= 8'h00;
      rd_pend     <= 1'b0;
      rd_oob      <= 1'b0;
      cpu_hold    <= 8'h00;
    end else begin
      rd_pend <= (state == GRANT) && !hs_write;
      rd_oob  <= !hs_win;
      if (state == GRANT && hs_write && !hs_win) hs_oob <= 1'b1;
      if (rd_pend) hs_data_out <= rd_oob ? HS_DATA_OOB : ram_rdata;
      if (state != GRANT) cpu_hold <= ram_rdata;
    end
  end
endmodule

// File: tb/tb_hiscore_ram_arbiter.sv
// Directed bench for hiscore_ram_arbiter with a behavioural 2K x 8 sync RAM.
module tb_hiscore_ram_arbiter;
  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] cpu_addr = '0;
  logic        cpu_ram_cs = 1'b0, cpu_we = 1'b0;
  logic [7:0]  cpu_dout = '0, cpu_din;
  logic [15:0] hs_address = '0;
  logic [7:0]  hs_data_in = '0, hs_data_out;
  logic        hs_write = 1'b0, hs_access_read = 1'b0, hs_access_write = 1'b0;
  logic        hs_pause, pause_cpu = 1'b0;
  logic [10:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata, ram_rdata = '0;
  logic        hs_granted, hs_oob, hs_abort;
  logic [7:0]  mem [0:2047];
  int          n_chk = 0, n_pass = 0;

  always #5 clk_sys = ~clk_sys;

  hiscore_ram_arbiter dut (
    .clk_sys(clk_sys), .reset(reset), .cpu_addr(cpu_addr), .cpu_ram_cs(cpu_ram_cs),
    .cpu_we(cpu_we), .cpu_dout(cpu_dout), .cpu_din(cpu_din), .hs_address(hs_address),
    .hs_data_in(hs_data_in), .hs_write(hs_write), .hs_access_read(hs_access_read),
    .hs_access_write(hs_access_write), .hs_data_out(hs_data_out), .hs_pause(hs_pause),
    .pause_cpu(pause_cpu), .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .hs_granted(hs_granted), .hs_oob(hs_oob), .hs_abort(hs_abort)
  );

  initial for (int i = 0; i < 2048; i++) mem[i] = 8'h00;

  always @(posedge clk_sys) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    n_chk++; if (hs_pause !== 1'b0) $display("FAIL reset_pause got %b want 0", hs_pause); else n_pass++;
    n_chk++; if (hs_granted !== 1'b0) $display("FAIL reset_granted got %b want 0", hs_granted); else n_pass++;
    n_chk++; if (hs_data_out !== 8'h00) $display("FAIL reset_hs_data got %h want 00", hs_data_out); else n_pass++;
    n_chk++; if (hs_oob !== 1'b0 || hs_abort !== 1'b0) $display("FAIL reset_sticky got oob=%b abort=%b want 0 0", hs_oob, hs_abort); else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_cpu_rw();
    cpu_addr = 16'h8010; cpu_ram_cs = 1'b1; cpu_we = 1'b1; cpu_dout = 8'h5A;
    #1;
    n_chk++; if (ram_we !== 1'b1 || ram_addr !== 11'h010) $display("FAIL cpu_wr_port got we=%b addr=%h want 1 010", ram_we, ram_addr); else n_pass++;
    step();
    cpu_we = 1'b0;
    #1;
    n_chk++; if (ram_we !== 1'b0) $display("FAIL cpu_wr_pulse got %b want 0", ram_we); else n_pass++;
    step();
    n_chk++; if (cpu_din !== 8'h5A) $display("FAIL cpu_rd got %h want 5a", cpu_din); else n_pass++;
    n_chk++; if (hs_pause !== 1'b0) $display("FAIL cpu_rw_pause got %b want 0", hs_pause); else n_pass++;
    cpu_ram_cs = 1'b0;
  endtask

  task automatic test_pause_wait();
    hs_address = 16'h8010; hs_access_read = 1'b1;
    step();
    n_chk++; if (hs_pause !== 1'b1) $display("FAIL req_pause got %b want 1", hs_pause); else n_pass++;
    for (int i = 0; i < 9; i++) begin
      step();
      n_chk++; if (hs_granted !== 1'b0 || hs_pause !== 1'b1) $display("FAIL req_hold%0d got gnt=%b pause=%b want 0 1", i, hs_granted, hs_pause); else n_pass++;
    end
    pause_cpu = 1'b1;
    step();  // acknowledge sampled here, drain starts
    for (int i = 0; i < 3; i++) begin
      step();
      n_chk++; if (hs_granted !== 1'b0) $display("FAIL drain%0d got gnt=%b want 0", i, hs_granted); else n_pass++;
    end
    step();
    n_chk++; if (hs_granted !== 1'b1) $display("FAIL grant_after_drain got %b want 1", hs_granted); else n_pass++;
  endtask

  task automatic test_grant_read();
    step();
    n_chk++; if (hs_data_out !== 8'h00) $display("FAIL hs_rd_early got %h want 00", hs_data_out); else n_pass++;
    step();
    n_chk++; if (hs_data_out !== 8'h5A) $display("FAIL hs_rd got %h want 5a", hs_data_out); else n_pass++;
    n_chk++; if (cpu_din !== 8'h5A) $display("FAIL cpu_din_hold got %h want 5a", cpu_din); else n_pass++;
  endtask

  task automatic test_grant_write();
    hs_access_write = 1'b1;
    hs_address = 16'h9000; hs_data_in = 8'hA5; hs_write = 1'b1;
    #1;
    n_chk++; if (ram_we !== 1'b0) $display("FAIL oob_we got %b want 0", ram_we); else n_pass++;
    step();
    n_chk++; if (hs_oob !== 1'b1) $display("FAIL oob_flag got %b want 1", hs_oob); else n_pass++;
    hs_address = 16'h8020;
    #1;
    n_chk++; if (ram_we !== 1'b1 || ram_addr !== 11'h020 || ram_wdata !== 8'hA5) $display("FAIL hs_wr_port got we=%b addr=%h d=%h want 1 020 a5", ram_we, ram_addr, ram_wdata); else n_pass++;
    step();
    hs_write = 1'b0;
    #1;
    n_chk++; if (ram_we !== 1'b0) $display("FAIL hs_wr_pulse got %b want 0", ram_we); else n_pass++;
    step();
    step();
    n_chk++; if (hs_data_out !== 8'hA5) $display("FAIL hs_rdback got %h want a5", hs_data_out); else n_pass++;
    n_chk++; if (cpu_din !== 8'h5A) $display("FAIL cpu_isolated got %h want 5a", cpu_din); else n_pass++;
    n_chk++; if (hs_oob !== 1'b1) $display("FAIL oob_sticky got %b want 1", hs_oob); else n_pass++;
    hs_address = 16'h9000;
    step();
    step();
    n_chk++; if (hs_data_out !== 8'hFF) $display("FAIL oob_rd got %h want ff", hs_data_out); else n_pass++;
  endtask

  task automatic test_abort();
    pause_cpu = 1'b0;
    step();
    n_chk++; if (hs_granted !== 1'b0 || hs_pause !== 1'b0 || hs_abort !== 1'b1) $display("FAIL abort got gnt=%b pause=%b abort=%b want 0 0 1", hs_granted, hs_pause, hs_abort); else n_pass++;
    step();
    n_chk++; if (hs_pause !== 1'b0) $display("FAIL abort_idle_pause got %b want 0", hs_pause); else n_pass++;
    step();
    n_chk++; if (hs_pause !== 1'b1 || hs_granted !== 1'b0) $display("FAIL rereq got pause=%b gnt=%b want 1 0", hs_pause, hs_granted); else n_pass++;
    n_chk++; if (hs_data_out !== 8'hFF) $display("FAIL hs_data_hold got %h want ff", hs_data_out); else n_pass++;
  endtask

  task automatic test_drain_drop();
    pause_cpu = 1'b1;
    step();
    step();  // counter now 2
    hs_access_read = 1'b0; hs_access_write = 1'b0;
    hs_address = 16'h8030; hs_data_in = 8'h77; hs_write = 1'b1;
    #1;
    n_chk++; if (ram_we !== 1'b0) $display("FAIL drain_wr_ignored got %b want 0", ram_we); else n_pass++;
    step();
    n_chk++; if (hs_pause !== 1'b0 || hs_granted !== 1'b0) $display("FAIL drain_release got pause=%b gnt=%b want 0 0", hs_pause, hs_granted); else n_pass++;
    n_chk++; if (ram_we !== 1'b0) $display("FAIL release_wr_ignored got %b want 0", ram_we); else n_pass++;
    step();
    n_chk++; if (hs_granted !== 1'b0 || mem[11'h030] !== 8'h00) $display("FAIL drain_no_grant got gnt=%b mem=%h want 0 00", hs_granted, mem[11'h030]); else n_pass++;
    hs_write = 1'b0;
  endtask

  task automatic test_reset_in_grant();
    hs_access_write = 1'b1; hs_address = 16'h8040;
    for (int i = 0; i < 6; i++) step();
    n_chk++; if (hs_granted !== 1'b1) $display("FAIL regrant got %b want 1", hs_granted); else n_pass++;
    reset = 1'b1; cpu_addr = 16'h8123;
    step();
    n_chk++; if (hs_pause !== 1'b0 || hs_granted !== 1'b0) $display("FAIL grant_reset got pause=%b gnt=%b want 0 0", hs_pause, hs_granted); else n_pass++;
    n_chk++; if (hs_oob !== 1'b0 || hs_abort !== 1'b0 || hs_data_out !== 8'h00) $display("FAIL grant_reset_regs got oob=%b abort=%b d=%h want 0 0 00", hs_oob, hs_abort, hs_data_out); else n_pass++;
    n_chk++; if (ram_addr !== 11'h123) $display("FAIL grant_reset_port got %h want 123", ram_addr); else n_pass++;
    hs_access_write = 1'b0;
    reset = 1'b0;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_cpu_rw();
    test_pause_wait();
    test_grant_read();
    test_grant_write();
    test_abort();
    test_drain_drop();
    test_reset_in_grant();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
